// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 31-channel, 2-bit TDM receive path.
package tdm_pkg;

   localparam int NUM_CH      = 31;
   localparam int W           = 2;
   localparam int SEL_W       = 5;
   localparam int FRAME_CNT_W = 8;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

endpackage

// File: rtl/tdm_shadow_bank.sv
// Write-indexed sample bank that collects one frame before it is committed.
module tdm_shadow_bank #(
   parameter int NUM_CH = tdm_pkg::NUM_CH,
   parameter int W      = tdm_pkg::W,
   parameter int SEL_W  = tdm_pkg::SEL_W
) (
   input  logic                clk,
   input  logic                we,
   input  logic [SEL_W-1:0]    idx,
   input  logic [W-1:0]        data,
   output logic [NUM_CH*W-1:0] rd_flat
);

   // Contents are don't-care until a frame is collected, so no reset.
   logic [NUM_CH*W-1:0] mem;

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx*W +: W] <= data;
      end
   end

   assign rd_flat = mem;

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: scatters beat k of each frame into channel k and
// commits the whole frame to out_flat atomically.
module tdm_demux #(
   parameter int NUM_CH = tdm_pkg::NUM_CH,
   parameter int W      = tdm_pkg::W,
   parameter int SEL_W  = tdm_pkg::SEL_W
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   input  logic                               in_sof,
   input  logic [W-1:0]                       in_data,
   output logic                               in_ready,
   output logic [NUM_CH*W-1:0]                out_flat,
   output logic [SEL_W-1:0]                   cur_sel,
   output logic                               frame_done,
   output logic                               sync_err,
   output logic [tdm_pkg::FRAME_CNT_W-1:0]    frame_cnt
);

   import tdm_pkg::*;

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   state_t              state;
   logic [SEL_W-1:0]    ch;
   logic                accept;
   logic                wr_en;
   logic [SEL_W-1:0]    wr_idx;
   logic [NUM_CH*W-1:0] rd_flat;

   always_comb begin
      in_ready = (state != COMMIT);
      cur_sel  = (state == COLLECT) ? ch : '0;
      accept   = in_valid & in_ready;
      wr_en    = accept & (in_sof | (state == COLLECT));
      wr_idx   = in_sof ? '0 : ch;
   end

   tdm_shadow_bank #(
      .NUM_CH (NUM_CH),
      .W      (W),
      .SEL_W  (SEL_W)
   ) u_shadow (
      .clk     (clk),
      .we      (wr_en),
      .idx     (wr_idx),
      .data    (in_data),
      .rd_flat (rd_flat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= HUNT;
         ch         <= '0;
         out_flat   <= '0;
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         sync_err   <= 1'b0;
         case (state)
            HUNT: begin
               if (accept && in_sof) begin
                  if (NUM_CH == 1) begin
                     state <= COMMIT;
                  end else begin
                     ch    <= SEL_W'(1);
                     state <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  // A premature sof restarts the frame; stale entries get overwritten before commit.
                  if (in_sof) begin
                     sync_err <= 1'b1;
                     ch       <= SEL_W'(1);
                  end else if (ch == LAST_CH) begin
                     state <= COMMIT;
                  end else begin
                     ch <= ch + SEL_W'(1);
                  end
               end
            end
            COMMIT: begin
               out_flat   <= rd_flat;
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + 1'b1;
               ch         <= '0;
               state      <= HUNT;
            end
            default: begin
               state <= HUNT;
               ch    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: drivers push expected commits, a monitor checks them on frame_done.
module tb_tdm_demux;

   localparam int NUM_CH = 31;
   localparam int W      = 2;
   localparam int SEL_W  = 5;
   localparam int FW     = NUM_CH * W;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_sof = 1'b0;
   logic [W-1:0]    in_data = '0;
   logic            in_ready;
   logic [FW-1:0]   out_flat;
   logic [SEL_W-1:0] cur_sel;
   logic            frame_done;
   logic            sync_err;
   logic [7:0]      frame_cnt;

   tdm_demux #(.NUM_CH(NUM_CH), .W(W), .SEL_W(SEL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_flat   (out_flat),
      .cur_sel    (cur_sel),
      .frame_done (frame_done),
      .sync_err   (sync_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [FW-1:0] flat;
      logic [7:0]    cnt;
   } exp_t;

   exp_t     sb_q[$];
   int       total = 0;
   int       bad   = 0;
   int       fd_count = 0;
   int       se_count = 0;
   int       busy_count = 0;
   logic [7:0] exp_cnt = 8'd0;
   logic     prev_fd = 1'b0;
   logic     prev_se = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: compare every commit against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && !in_ready) busy_count++;
         if (sync_err) begin
            se_count++;
            chk("sync_err_single_cycle", {63'd0, prev_se}, 64'd0);
         end
         prev_se = sync_err;
         if (frame_done) begin
            fd_count++;
            chk("frame_done_single_cycle", {63'd0, prev_fd}, 64'd0);
            if (sb_q.size() == 0) begin
               chk("unexpected_frame_done", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("commit_out_flat", {2'b00, out_flat}, {2'b00, e.flat});
               chk("commit_frame_cnt", {56'd0, frame_cnt}, {56'd0, e.cnt});
            end
         end
         prev_fd = frame_done;
      end
   end

   // Drives one beat, holding it while in_ready is low; returns cycles spent waiting.
   task automatic beat(input logic s, input logic [W-1:0] d, output int waited);
      waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = s;
      in_data  = d;
      while (!in_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 10) begin
         chk("in_ready_timeout", 64'd0, 64'd1);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input logic [FW-1:0] f, output int first_wait);
      int w;
      exp_t e;
      first_wait = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         beat(k == 0, f[k*W +: W], w);
         if (k == 0) first_wait = w;
      end
      exp_cnt = exp_cnt + 8'd1;
      e.flat  = f;
      e.cnt   = exp_cnt;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb_q.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   function automatic logic [FW-1:0] fill(input logic [W-1:0] d);
      logic [FW-1:0] f;
      for (int k = 0; k < NUM_CH; k++) f[k*W +: W] = d;
      return f;
   endfunction

   initial begin
      logic [FW-1:0] f;
      int w, fd0, se0, busy0;

      // Reset values while rst is held
      #12;
      chk("rst_out_flat", {2'b00, out_flat}, 64'd0);
      chk("rst_frame_cnt", {56'd0, frame_cnt}, 64'd0);
      chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
      chk("rst_sync_err", {63'd0, sync_err}, 64'd0);
      chk("rst_cur_sel", {59'd0, cur_sel}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: data = k % 4, with explicit timing of the commit
      for (int k = 0; k < NUM_CH; k++) f[k*W +: W] = W'(k % 4);
      send_frame(f, w);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t1_commit_cycle_not_ready", {63'd0, in_ready}, 64'd0);
      chk("t1_no_done_in_commit", {63'd0, frame_done}, 64'd0);
      @(negedge clk);
      chk("t1_done_after_commit", {63'd0, frame_done}, 64'd1);
      chk("t1_ch12", {62'd0, out_flat[12*W +: W]}, 64'd0);
      chk("t1_ch13", {62'd0, out_flat[13*W +: W]}, 64'd1);
      chk("t1_ch30", {62'd0, out_flat[30*W +: W]}, 64'd2);
      chk("t1_frame_cnt", {56'd0, frame_cnt}, 64'd1);
      drain();

      // Test 2: leading beats without sof are dropped
      beat(1'b0, 2'b01, w);
      chk("t2_hunt_cur_sel", {59'd0, cur_sel}, 64'd0);
      beat(1'b0, 2'b10, w);
      beat(1'b0, 2'b01, w);
      send_frame(fill(2'b11), w);
      idle();
      drain();
      chk("t2_all_ones", {2'b00, out_flat}, {2'b00, fill(2'b11)});

      // Test 3: restart mid-frame
      fd0 = fd_count;
      se0 = se_count;
      beat(1'b1, 2'b01, w);
      for (int k = 1; k <= 10; k++) beat(1'b0, 2'b01, w);
      @(negedge clk);
      chk("t3_cur_sel_mid", {59'd0, cur_sel}, 64'd11);
      send_frame(fill(2'b10), w);
      idle();
      drain();
      repeat (3) @(negedge clk);
      chk("t3_sync_err_once", se_count - se0, 64'd1);
      chk("t3_one_frame_done", fd_count - fd0, 64'd1);
      chk("t3_all_twos", {2'b00, out_flat}, {2'b00, fill(2'b10)});

      // Test 4: back-to-back frames, second sof offered during COMMIT
      busy0 = busy_count;
      send_frame(fill(2'b01), w);
      for (int k = 0; k < NUM_CH; k++) f[k*W +: W] = W'((k * 3 + 1) % 4);
      send_frame(f, w);
      chk("t4_sof_waited_one", w, 64'd1);
      idle();
      drain();
      chk("t4_busy_cycles", busy_count - busy0, 64'd2);
      chk("t4_second_frame", {2'b00, out_flat}, {2'b00, f});

      // Test 5: 256 frames, frame_cnt wraps to its start value
      fd0 = fd_count;
      for (int n = 0; n < 256; n++) begin
         for (int k = 0; k < NUM_CH; k++) f[k*W +: W] = W'((k + n) % 4);
         send_frame(f, w);
      end
      idle();
      drain();
      chk("t5_done_256", fd_count - fd0, 64'd256);
      chk("t5_cnt_wrapped", {56'd0, frame_cnt}, {56'd0, exp_cnt});

      // Test 6: reset mid-frame discards it
      send_frame(fill(2'b11), w);
      for (int k = 0; k < 20; k++) beat(k == 0, 2'b01, w);
      idle();
      drain();
      fd0 = fd_count;
      rst = 1'b1;
      #1;
      chk("t6_out_flat_cleared", {2'b00, out_flat}, 64'd0);
      chk("t6_frame_cnt_cleared", {56'd0, frame_cnt}, 64'd0);
      chk("t6_hunt_ready", {63'd0, in_ready}, 64'd1);
      chk("t6_hunt_sel", {59'd0, cur_sel}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 8'd0;
      repeat (2) @(negedge clk);
      chk("t6_no_frame_done", fd_count - fd0, 64'd0);
      for (int k = 0; k < NUM_CH; k++) f[k*W +: W] = W'((k / 2) % 4);
      send_frame(f, w);
      idle();
      drain();
      chk("t6_post_reset_frame", {2'b00, out_flat}, {2'b00, f});
      chk("t6_post_reset_cnt", {56'd0, frame_cnt}, 64'd1);

      repeat (2) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
